// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding,
// reset/ROM defaults and the opcode length decode.
// Optional bounds checking is selected by the FETCH_BOUNDS_CHECK_EN macro.
package fetch_unit_pkg;

  localparam logic [7:0] DEF_RESET_VEC = 8'h00;
  localparam logic [7:0] DEF_ROM_TOP   = 8'h7F;

  typedef enum logic [2:0] {
    ST_ADDR  = 3'd0,
    ST_OPC   = 3'd1,
    ST_OPRA  = 3'd2,
    ST_OPR   = 3'd3,
`ifdef FETCH_BOUNDS_CHECK_EN
    ST_VALID = 3'd4,
    ST_ERR   = 3'd5
`else
    ST_VALID = 3'd4
`endif
  } fetch_state_t;

  // An opcode carries an operand byte when bit 7 is set or its upper nibble is 2.
  function automatic logic is_two_byte(input logic [7:0] opcode);
    return opcode[7] || (opcode[7:4] == 4'h2);
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// 8-bit program counter with load, increment and asynchronous active-low reset.
// Load wins over increment; increment wraps modulo 256.
module pc_reg #(
  parameter logic [7:0] RESET_VEC = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] target,
  input  logic       inc,
  output logic [7:0] pc
);

  // PC update: reset vector, redirect target, or next sequential byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_VEC;
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: reads one- or two-byte instructions from a
// synchronous-read memory and hands them to the execute stage via valid/ready.
// Define FETCH_BOUNDS_CHECK_EN to trap fetches above ROM_TOP in an ERR state.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [7:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [7:0] ROM_TOP   = DEF_ROM_TOP
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] mem_address,
  input  logic [7:0] mem_data,
  output logic       mem_write,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_operand,
  output logic [7:0] instr_pc,
  output logic       instr_valid,
  input  logic       instr_ready,
  input  logic       pc_load,
  input  logic [7:0] pc_target,
  output logic       fetch_err
);

  fetch_state_t state, state_next;
  logic [7:0]   pc;
  logic         pc_inc;
  logic         cap_pc;
  logic         cap_opc;
  logic         cap_opr;
  logic         clr_opr;
  logic         addr_oob;

  pc_reg #(
    .RESET_VEC(RESET_VEC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .load  (pc_load),
    .target(pc_target),
    .inc   (pc_inc),
    .pc    (pc)
  );

  assign mem_address = pc;
  assign mem_write   = 1'b0;
  assign instr_valid = (state == ST_VALID);

`ifdef FETCH_BOUNDS_CHECK_EN
  assign addr_oob  = (pc > ROM_TOP);
  assign fetch_err = (state == ST_ERR);
`else
  logic unused_rom_top;
  assign unused_rom_top = ^ROM_TOP;
  assign addr_oob       = 1'b0;
  assign fetch_err      = 1'b0;
`endif

  // State register; reset abandons any fetch and restarts at ADDR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_ADDR;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and datapath strobes; a redirect overrides everything else.
  always_comb begin
    state_next = state;
    pc_inc     = 1'b0;
    cap_pc     = 1'b0;
    cap_opc    = 1'b0;
    cap_opr    = 1'b0;
    clr_opr    = 1'b0;
    case (state)
      ST_ADDR: begin
        if (addr_oob) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          state_next = ST_ERR;
`endif
        end else begin
          cap_pc     = 1'b1;
          pc_inc     = 1'b1;
          state_next = ST_OPC;
        end
      end
      ST_OPC: begin
        cap_opc = 1'b1;
        if (is_two_byte(mem_data)) begin
          state_next = ST_OPRA;
        end else begin
          clr_opr    = 1'b1;
          state_next = ST_VALID;
        end
      end
      ST_OPRA: begin
        if (addr_oob) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          state_next = ST_ERR;
`endif
        end else begin
          pc_inc     = 1'b1;
          state_next = ST_OPR;
        end
      end
      ST_OPR: begin
        cap_opr    = 1'b1;
        state_next = ST_VALID;
      end
      ST_VALID: begin
        if (instr_ready) begin
          state_next = ST_ADDR;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      ST_ERR: begin
        state_next = ST_ERR;
      end
`endif
      default: begin
        state_next = ST_ADDR;
      end
    endcase
    if (pc_load) begin
      state_next = ST_ADDR;
      pc_inc     = 1'b0;
      cap_pc     = 1'b0;
      cap_opc    = 1'b0;
      cap_opr    = 1'b0;
      clr_opr    = 1'b0;
    end
  end

  // Instruction capture registers; they only change outside VALID, so the
  // presented instruction stays stable while the execute stage stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_pc      <= 8'h00;
      instr_opcode  <= 8'h00;
      instr_operand <= 8'h00;
    end else begin
      if (cap_pc) begin
        instr_pc <= pc;
      end
      if (cap_opc) begin
        instr_opcode <= mem_data;
      end
      if (cap_opr) begin
        instr_operand <= mem_data;
      end else if (clr_opr) begin
        instr_operand <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// instruction stream checked against a transaction-level fetch model.
module tb_fetch_unit;

  localparam logic [7:0] EXP_RESET_VEC = 8'h00;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] mem_address;
  logic [7:0] mem_data;
  logic       mem_write;
  logic [7:0] instr_opcode;
  logic [7:0] instr_operand;
  logic [7:0] instr_pc;
  logic       instr_valid;
  logic       instr_ready;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       fetch_err;

  logic [7:0] mem [256];
  int         errors = 0;
  int         checks = 0;

  fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .instr_opcode (instr_opcode),
    .instr_operand(instr_operand),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_load      (pc_load),
    .pc_target    (pc_target),
    .fetch_err    (fetch_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Synchronous-read memory: data appears one cycle after the address is sampled.
  always @(posedge clk) mem_data <= mem[mem_address];

  function automatic bit isTwoByte(input logic [7:0] op);
    return (op >= 8'h80) || (op >= 8'h20 && op <= 8'h2F);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ready, input logic load, input logic [7:0] target);
    instr_ready = ready;
    pc_load     = load;
    pc_target   = target;
  endtask

  // Pulse reset across one cycle; returns at a falling edge with the DUT in ADDR.
  task automatic doReset();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Count falling edges until instr_valid, bounded so a stuck DUT cannot hang.
  task automatic waitValid(output int lat);
    lat = 0;
    while (instr_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Fetch one instruction starting from ADDR at pc, optionally stalling the
  // handshake, and check it against the model. Returns the next fetch address.
  task automatic checkInstr(input string tag, input logic [7:0] pc, input int stall,
                            output logic [7:0] next_pc);
    logic [7:0] op;
    logic [7:0] opr;
    logic [7:0] pc1;
    int         lat;
    int         exp_lat;
    pc1     = pc + 8'd1;
    op      = mem[pc];
    opr     = isTwoByte(op) ? mem[pc1] : 8'h00;
    exp_lat = isTwoByte(op) ? 4 : 2;
    next_pc = isTwoByte(op) ? pc + 8'd2 : pc1;
    checkOutput({tag, "_addr"}, mem_address, pc);
    applyStimulus(stall == 0, 1'b0, 8'h00);
    waitValid(lat);
    checkOutput({tag, "_latency"}, lat, exp_lat);
    checkOutput({tag, "_opcode"}, instr_opcode, op);
    checkOutput({tag, "_operand"}, instr_operand, opr);
    checkOutput({tag, "_pc"}, instr_pc, pc);
    checkOutput({tag, "_err"}, fetch_err, 1'b0);
    checkOutput({tag, "_wr"}, mem_write, 1'b0);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      checkOutput({tag, "_stall_valid"}, instr_valid, 1'b1);
      checkOutput({tag, "_stall_opcode"}, instr_opcode, op);
      checkOutput({tag, "_stall_operand"}, instr_operand, opr);
      checkOutput({tag, "_stall_pc"}, instr_pc, pc);
      checkOutput({tag, "_stall_addr"}, mem_address, next_pc);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_done_valid"}, instr_valid, 1'b0);
  endtask

  initial begin
    logic [7:0] pc;
    logic [7:0] nxt;
    int         lat;
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);

    // One-byte instruction straight out of reset.
    mem[8'h00] = 8'h43;
    doReset();
    checkOutput("rst_addr", mem_address, EXP_RESET_VEC);
    checkOutput("rst_valid", instr_valid, 1'b0);
    checkOutput("rst_err", fetch_err, 1'b0);
    checkInstr("one_byte", 8'h00, 0, nxt);
    checkOutput("one_byte_next", mem_address, 8'h01);

    // Two-byte instruction, then a 5-cycle stall on the following one.
    mem[8'h00] = 8'h86;
    mem[8'h01] = 8'hAA;
    mem[8'h02] = 8'h25;
    mem[8'h03] = 8'h5C;
    doReset();
    checkInstr("two_byte", 8'h00, 0, nxt);
    checkOutput("two_byte_next", mem_address, 8'h02);
    checkInstr("stall", nxt, 5, nxt);
    checkOutput("stall_next", mem_address, 8'h04);

    // Redirect during OPRA drops the partial instruction.
    doReset();
    @(negedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 1'b1, 8'h40);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("redir_valid", instr_valid, 1'b0);
    checkInstr("redir", 8'h40, 1, nxt);

    // Reset asserted during OPR clears outputs at once and restarts at the vector.
    doReset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("midrst_valid", instr_valid, 1'b0);
    checkOutput("midrst_opcode", instr_opcode, 8'h00);
    checkOutput("midrst_operand", instr_operand, 8'h00);
    checkOutput("midrst_pc", instr_pc, 8'h00);
    checkOutput("midrst_addr", mem_address, EXP_RESET_VEC);
    checkOutput("midrst_err", fetch_err, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    checkInstr("after_rst", EXP_RESET_VEC, 0, nxt);

`ifndef FETCH_BOUNDS_CHECK_EN
    // Operand byte of an instruction at FF comes from address 00.
    mem[8'hFF] = 8'h9C;
    mem[8'h00] = 8'h3E;
    applyStimulus(1'b1, 1'b1, 8'hFF);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkInstr("wrap", 8'hFF, 0, nxt);
    checkOutput("wrap_next", mem_address, 8'h01);
`else
    // Fetch above ROM_TOP traps until the next redirect.
    applyStimulus(1'b1, 1'b1, 8'h80);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("oob_err", fetch_err, 1'b1);
      checkOutput("oob_valid", instr_valid, 1'b0);
    end
    applyStimulus(1'b1, 1'b1, 8'h10);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("oob_clear", fetch_err, 1'b0);
    checkInstr("oob_recover", 8'h10, 0, nxt);
`endif

    // Randomized stream with random stalls and occasional redirects.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    doReset();
    pc = EXP_RESET_VEC;
    for (int n = 0; n < 40; n++) begin
      if (n % 7 == 6) begin
        pc = 8'($urandom_range(0, 8'h70));
        applyStimulus(1'b1, 1'b1, pc);
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("rnd_redir_valid", instr_valid, 1'b0);
      end
      checkInstr("rnd", pc, $urandom_range(0, 3), nxt);
      pc = nxt;
    end

    lat = 0;
    $display("[TB] directed and random sequences complete (%0d)", lat);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_VEC, default 8'h00, meaning PC value loaded on reset.
REQ-002 SHALL have parameter ROM_TOP, default 8'h7F, meaning highest legal fetch address when bounds checking is compiled in.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mem_address  output  8  registered fetch address to the memory system, always equal to the PC register.
REQ-006 SHALL have port mem_data  input  8  memory read data, valid one cycle after mem_address is sampled.
REQ-007 SHALL have port mem_write  output  1  tied 0; the fetch unit never writes.
REQ-008 SHALL have ports instr_opcode, instr_operand, instr_pc  output  8 each  captured instruction bytes and the opcode's address.
REQ-009 SHALL have ports instr_valid output 1 and instr_ready input 1  valid/ready handshake to the execute stage.
REQ-010 SHALL have ports pc_load input 1 and pc_target input 8  redirect request from the execute stage.
REQ-011 SHALL have port fetch_err  output  1  illegal-fetch-address flag.

Function
REQ-012 SHALL implement states ADDR, OPC, OPRA, OPR, VALID, plus ERR only when REQ-027 is compiled in.
REQ-013 ADDR SHALL hold PC for one cycle, set instr_pc<=PC, then PC<=PC+1 and go to OPC.
REQ-014 OPC SHALL capture instr_opcode<=mem_data; a two-byte opcode goes to OPRA, otherwise instr_operand<=8'h00 and go to VALID.
REQ-015 Two-byte opcodes SHALL be those with bit 7 set or upper nibble 4'h2.
REQ-016 OPRA SHALL hold PC one cycle then PC<=PC+1 and go to OPR; OPR SHALL capture instr_operand<=mem_data and go to VALID.
REQ-017 instr_valid SHALL be 1 only in VALID; instr_* outputs SHALL be stable while instr_valid=1 and instr_ready=0.
REQ-018 VALID with instr_ready=1 SHALL complete the transfer and go to ADDR next cycle.
REQ-019 Latency: one-byte instruction valid 2 cycles after entering ADDR; two-byte 4 cycles.
REQ-020 PC arithmetic SHALL be 8-bit modulo; 8'hFF+1 wraps to 8'h00, including between opcode and operand.
REQ-021 pc_load=1 in any state SHALL set PC<=pc_target, discard any partial instruction, deassert instr_valid next cycle, and go to ADDR.
REQ-022 pc_load SHALL take priority over instr_ready, the PC increment, and ERR.

Reset
REQ-023 Reset assertion SHALL immediately set PC=RESET_VEC, state=ADDR, instr_valid=0, instr_opcode=instr_operand=instr_pc=8'h00, fetch_err=0.
REQ-024 Reset asserted mid-fetch SHALL abandon the fetch; after deassertion the first fetch is from RESET_VEC.
REQ-025 Reset deassertion SHALL be accepted on any edge; no recovery cycles required.

Configuration
REQ-026 Macro FETCH_BOUNDS_CHECK_EN SHALL select bounds checking.
REQ-027 When defined, entering ADDR or OPRA with PC>ROM_TOP SHALL go to ERR; ERR SHALL assert fetch_err=1, hold instr_valid=0, and leave only via pc_load or reset.
REQ-028 When undefined, fetch_err SHALL be constant 0, no ERR state SHALL exist, and all 256 addresses are fetchable.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the two-byte-opcode decode function, and RESET_VEC/ROM_TOP defaults.
REQ-030 One sub-module, pc_reg (8-bit PC with load/increment/reset), is natural; the FSM and capture registers stay in fetch_unit.

Verification
REQ-031 Memory[00]=8'h43, instr_ready=1 -> instr_valid on cycle 2 with opcode 43, operand 00, pc 00.
REQ-032 Memory[00..01]=86,AA -> valid on cycle 4 with opcode 86, operand AA; next fetch from 02.
REQ-033 instr_ready=0 for 5 cycles in VALID -> outputs stable, PC unchanged, no memory advance.
REQ-034 pc_load=1, pc_target=8'h40 during OPRA -> partial instruction dropped; next instr_pc=40.
REQ-035 PC=FF with two-byte opcode -> operand fetched from 00; with FETCH_BOUNDS_CHECK_EN, PC=80 -> fetch_err=1 until pc_load.
REQ-036 Reset low during OPR -> all outputs 0 immediately; after release first mem_address=RESET_VEC.
